timer_array: RTL

Parametrised multi-channel timer peripheral, the successor to the two single-channel TC instances hanging off the Bridge. One block provides NUM_CH independent down-counters, each with one-shot or auto-reload mode, a per-channel prescaler, a sticky pending flag with write-1-to-clear acknowledge, and a maskable interrupt line. Its output vector feeds HWInt of CP0. It sits on the Bridge's word-addressed device port.

---
 rtl/timer_array.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/timer_array.sv
// Multi-channel down-counter timer block: per-channel prescaler, one-shot or
// auto-reload mode, sticky pending flag with write-1-to-clear, maskable IRQ.
module timer_array #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    output logic [NUM_CH-1:0] IRQ,
    output logic              IRQ_any
);

    localparam int unsigned PS_W      = 8;
    localparam int unsigned NUM_WORDS = 4 * NUM_CH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CNT
    } state_t;

    state_t state_q [NUM_CH];
    state_t state_d [NUM_CH];

    logic [NUM_CH-1:0]            en_q,   en_d;
    logic [NUM_CH-1:0]            mode_q, mode_d;
    logic [NUM_CH-1:0]            im_q,   im_d;
    logic [NUM_CH-1:0]            pend_q, pend_d;
    logic [NUM_CH-1:0][PS_W-1:0]  ps_q,    ps_d;
    logic [NUM_CH-1:0][PS_W-1:0]  presc_q, presc_d;
    logic [NUM_CH-1:0][WIDTH-1:0] preset_q, preset_d;
    logic [NUM_CH-1:0][WIDTH-1:0] count_q,  count_d;

    logic              addr_ok;
    logic [ADDR_W-1:0] ch_idx;
    logic [1:0]        reg_sel;
    logic [NUM_CH-1:0] wr_ctrl, wr_preset, wr_status;
    logic [NUM_CH-1:0] fire;
    logic              unused_din;

    assign addr_ok    = ({1'b0, Addr} < (ADDR_W + 1)'(NUM_WORDS));
    assign ch_idx     = Addr >> 2;
    assign reg_sel    = Addr[1:0];
    assign unused_din = ^Din;

    // Per-channel write strobes decoded from the word address
    always_comb begin
        wr_ctrl   = '0;
        wr_preset = '0;
        wr_status = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (WE && addr_ok && (ch_idx == ADDR_W'(i))) begin
                wr_ctrl[i]   = (reg_sel == 2'd0);
                wr_preset[i] = (reg_sel == 2'd1);
                wr_status[i] = (reg_sel == 2'd3);
            end
        end
    end

    // Next-state and counter datapath; a CTRL write overrides counting on its edge
    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        mode_d   = mode_q;
        im_d     = im_q;
        pend_d   = pend_q;
        ps_d     = ps_q;
        presc_d  = presc_q;
        preset_d = preset_q;
        count_d  = count_q;
        fire     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            case (state_q[i])
                ST_LOAD: begin
                    count_d[i] = preset_q[i];
                    presc_d[i] = '0;
                    state_d[i] = ST_CNT;
                end
                ST_CNT: begin
                    if (presc_q[i] == ps_q[i]) begin
                        presc_d[i] = '0;
                        if (count_q[i] > WIDTH'(1)) begin
                            count_d[i] = count_q[i] - WIDTH'(1);
                        end else begin
                            fire[i] = 1'b1;
                            if (mode_q[i]) begin
                                count_d[i] = preset_q[i];
                            end else begin
                                count_d[i] = '0;
                                en_d[i]    = 1'b0;
                                state_d[i] = ST_IDLE;
                            end
                        end
                    end else begin
                        presc_d[i] = presc_q[i] + PS_W'(1);
                    end
                end
                default: ;
            endcase

            // Set beats a same-edge write-1 clear
            pend_d[i] = fire[i] | (pend_q[i] & ~(wr_status[i] & Din[0]));

            if (wr_preset[i]) begin
                preset_d[i] = Din[WIDTH-1:0];
            end

            if (wr_ctrl[i]) begin
                en_d[i]    = Din[0];
                mode_d[i]  = Din[1];
                im_d[i]    = Din[3];
                ps_d[i]    = Din[15:8];
                pend_d[i]  = 1'b0;
                count_d[i] = count_q[i];
                presc_d[i] = presc_q[i];
                state_d[i] = Din[0] ? ST_LOAD : ST_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= ST_IDLE;
            end
            en_q     <= '0;
            mode_q   <= '0;
            im_q     <= '0;
            pend_q   <= '0;
            ps_q     <= '0;
            presc_q  <= '0;
            preset_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
            end
            en_q     <= en_d;
            mode_q   <= mode_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            ps_q     <= ps_d;
            presc_q  <= presc_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

    // Combinational read mux; out-of-range addresses read zero
    always_comb begin
        Dout = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (addr_ok && (ch_idx == ADDR_W'(i))) begin
                case (reg_sel)
                    2'd0:    Dout = {16'b0, ps_q[i], 4'b0, im_q[i], 1'b0, mode_q[i], en_q[i]};
                    2'd1:    Dout = 32'(preset_q[i]);
                    2'd2:    Dout = 32'(count_q[i]);
                    default: Dout = {31'b0, pend_q[i]};
                endcase
            end
        end
    end

    assign IRQ     = pend_q & im_q;
    assign IRQ_any = |IRQ;

endmodule
